// File: rtl/systolic_pkg.sv
// Shared FSM state type and accumulator sizing helper for the systolic
// matrix-multiply engine.
package systolic_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_e;

   function automatic int acc_width(input int data_width, input int max_k);
      return 2 * data_width + $clog2(max_k);
   endfunction

endpackage

// File: rtl/systolic_pe.sv
// One output-stationary MAC cell: forwards data east and weight south,
// accumulating their full-width product only on array steps.
module systolic_pe
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = acc_width(16, 256),
   parameter int SIGNED     = 1
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic                  step,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH-1:0] a_o,
   output logic [DATA_WIDTH-1:0] b_o,
   output logic [ACC_WIDTH-1:0]  acc_o
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam bit SX = (SIGNED != 0);

   logic [PW-1:0]         a_ext, b_ext, prod;
   logic [ACC_WIDTH-1:0]  prod_ext;
   logic [DATA_WIDTH-1:0] a_q, b_q;
   logic [ACC_WIDTH-1:0]  acc_q;

   // Extending to 2*DW first makes the low 2*DW product bits correct for both signednesses.
   always_comb begin
      a_ext    = {{DATA_WIDTH{SX & a_i[DATA_WIDTH-1]}}, a_i};
      b_ext    = {{DATA_WIDTH{SX & b_i[DATA_WIDTH-1]}}, b_i};
      prod     = a_ext * b_ext;
      prod_ext = {{(ACC_WIDTH-PW){SX & prod[PW-1]}}, prod};
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else if (step) begin
         a_q   <= a_i;
         b_q   <= b_i;
         acc_q <= acc_q + prod_ext;
      end
   end

   assign a_o   = a_q;
   assign b_o   = b_q;
   assign acc_o = acc_q;

endmodule

// File: rtl/systolic_mm_stream.sv
// Output-stationary NxN systolic matrix multiplier with internal operand skew,
// self-sequenced load/flush/drain and row-per-beat result streaming.
module systolic_mm_stream
   import systolic_pkg::*;
#(
   parameter int  ARRAY_SIZE = 8,
   parameter int  DATA_WIDTH = 16,
   parameter int  MAX_K      = 256,
   parameter int  SIGNED     = 1,
   localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, MAX_K),
   localparam int KW         = $clog2(MAX_K) + 1,
   localparam int RW         = $clog2(ARRAY_SIZE)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [KW-1:0]                    k_len,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_d,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_w,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_row,
   output logic [RW-1:0]                    out_row_idx,
   output logic                             out_last,
   output logic                             busy,
   output logic                             done
);

   localparam int N  = ARRAY_SIZE;
   localparam int FW = $clog2(2 * N);

   state_e        state_q;
   logic [KW-1:0] k_len_q, beat_q;
   logic [FW-1:0] flush_q;
   logic [RW-1:0] row_q;
   logic          done_q;
   logic          start_acc, clear, step;

   logic [DATA_WIDTH-1:0] a_bus [N][N+1];
   logic [DATA_WIDTH-1:0] b_bus [N+1][N];
   logic [ACC_WIDTH-1:0]  acc   [N][N];

   assign start_acc = (state_q == IDLE) && start;
   assign clear     = rst || start_acc;
   assign step      = ((state_q == LOAD) && in_valid) || (state_q == FLUSH);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         k_len_q <= '0;
         beat_q  <= '0;
         flush_q <= '0;
         row_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  k_len_q <= k_len;
                  beat_q  <= '0;
                  flush_q <= '0;
                  row_q   <= '0;
                  state_q <= (k_len == '0) ? FLUSH : LOAD;
               end
            end
            LOAD: begin
               if (in_valid) begin
                  beat_q <= beat_q + KW'(1);
                  if (beat_q == k_len_q - KW'(1)) state_q <= FLUSH;
               end
            end
            FLUSH: begin
               flush_q <= flush_q + FW'(1);
               if (flush_q == FW'(2 * N - 2)) state_q <= DRAIN;
            end
            DRAIN: begin
               if (out_ready) begin
                  if (row_q == RW'(N - 1)) begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                     row_q   <= '0;
                  end else begin
                     row_q <= row_q + RW'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready    = (state_q == LOAD);
   assign out_valid   = (state_q == DRAIN);
   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign out_row_idx = row_q;
   assign out_last    = (state_q == DRAIN) && (row_q == RW'(N - 1));

   // Lane g is delayed g array steps so operands of the same k meet in every PE.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_lane
         logic [DATA_WIDTH-1:0] d_inj, w_inj;
         assign d_inj = (state_q == LOAD) ? in_d[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
         assign w_inj = (state_q == LOAD) ? in_w[gi*DATA_WIDTH +: DATA_WIDTH] : '0;

         if (gi == 0) begin : g_direct
            assign a_bus[gi][0] = d_inj;
            assign b_bus[0][gi] = w_inj;
         end else begin : g_delay
            logic [DATA_WIDTH-1:0] d_sr_q [gi];
            logic [DATA_WIDTH-1:0] w_sr_q [gi];
            always_ff @(posedge clk) begin
               if (clear) begin
                  for (int s = 0; s < gi; s++) begin
                     d_sr_q[s] <= '0;
                     w_sr_q[s] <= '0;
                  end
               end else if (step) begin
                  d_sr_q[0] <= d_inj;
                  w_sr_q[0] <= w_inj;
                  for (int s = 1; s < gi; s++) begin
                     d_sr_q[s] <= d_sr_q[s-1];
                     w_sr_q[s] <= w_sr_q[s-1];
                  end
               end
            end
            assign a_bus[gi][0] = d_sr_q[gi-1];
            assign b_bus[0][gi] = w_sr_q[gi-1];
         end
      end

      for (genvar gi = 0; gi < N; gi++) begin : g_row
         for (genvar gj = 0; gj < N; gj++) begin : g_col
            systolic_pe #(
               .DATA_WIDTH (DATA_WIDTH),
               .ACC_WIDTH  (ACC_WIDTH),
               .SIGNED     (SIGNED)
            ) u_pe (
               .clk   (clk),
               .clear (clear),
               .step  (step),
               .a_i   (a_bus[gi][gj]),
               .b_i   (b_bus[gi][gj]),
               .a_o   (a_bus[gi][gj+1]),
               .b_o   (b_bus[gi+1][gj]),
               .acc_o (acc[gi][gj])
            );
         end
      end

      for (genvar gi = 0; gi < N; gi++) begin : g_out
         assign out_row[gi*ACC_WIDTH +: ACC_WIDTH] = acc[row_q][gi];
      end
   endgenerate

endmodule

// File: tb/tb_systolic_mm_stream.sv
// Directed self-checking bench for systolic_mm_stream at N=4, DW=8, MAX_K=256, signed.
module tb_systolic_mm_stream;

   localparam int N    = 4;
   localparam int DW   = 8;
   localparam int MAXK = 256;
   localparam int ACCW = 2 * DW + 8;
   localparam int KW   = 9;
   localparam int TMO  = 2000;

   logic            clk = 1'b0;
   logic            rst, start, in_valid, out_ready;
   logic            in_ready, out_valid, out_last, busy, done;
   logic [KW-1:0]   k_len;
   logic [N*DW-1:0] in_d, in_w;
   logic [N*ACCW-1:0] out_row;
   logic [1:0]      out_row_idx;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int done_cnt = 0;
   int ready_cnt = 0;

   logic [DW-1:0]     vd [MAXK][N];
   logic [DW-1:0]     vw [MAXK][N];
   logic [N*ACCW-1:0] got_row [N];
   logic [1:0]        got_idx [N];
   logic              got_last [N];
   int                first_valid_cyc, done_cyc, last_beat_cyc;
   logic              done_at, done_next, tmo;

   systolic_mm_stream #(
      .ARRAY_SIZE (N),
      .DATA_WIDTH (DW),
      .MAX_K      (MAXK),
      .SIGNED     (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .k_len       (k_len),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_d        (in_d),
      .in_w        (in_w),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_row     (out_row),
      .out_row_idx (out_row_idx),
      .out_last    (out_last),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (in_ready) ready_cnt <= ready_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int k);
      k_len = KW'(k);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic feed(input int k, input bit gaps);
      int t;
      int g;
      for (int b = 0; b < k; b++) begin
         if (gaps) begin
            g = $urandom_range(0, 3);
            in_valid = 1'b0;
            repeat (g) tick();
         end
         for (int l = 0; l < N; l++) begin
            in_d[l*DW +: DW] = vd[b][l];
            in_w[l*DW +: DW] = vw[b][l];
         end
         in_valid = 1'b1;
         t = 0;
         while (!in_ready && t < TMO) begin
            tick();
            t++;
         end
         if (t >= TMO) tmo = 1'b1;
         tick();
         last_beat_cyc = cyc - 1;
      end
      in_valid = 1'b0;
      in_d = '0;
      in_w = '0;
   endtask

   task automatic collect();
      int t;
      out_ready = 1'b1;
      for (int r = 0; r < N; r++) begin
         t = 0;
         while (!out_valid && t < TMO) begin
            tick();
            t++;
         end
         if (t >= TMO) tmo = 1'b1;
         if (r == 0) first_valid_cyc = cyc;
         got_row[r]  = out_row;
         got_idx[r]  = out_row_idx;
         got_last[r] = out_last;
         tick();
      end
      done_at  = done;
      done_cyc = cyc;
      tick();
      done_next = done;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      k_len = KW'(4);
      tick();
      tick();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      checks++; if (out_row !== '0) begin errors++; $display("FAIL reset_out_row got=%h want=0", out_row); end
      checks++; if (out_row_idx !== 2'd0) begin errors++; $display("FAIL reset_out_row_idx got=%0d want=0", out_row_idx); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b want=0", out_last); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
      rst = 1'b0;
      start = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_beats_start busy got=%b want=0", busy); end
      $display("test_reset done");
   endtask

   task automatic test_identity();
      logic [N*ACCW-1:0] exp_row;
      tmo = 1'b0;
      for (int k = 0; k < 4; k++)
         for (int l = 0; l < N; l++) begin
            vd[k][l] = (l == k) ? DW'(1) : DW'(0);
            vw[k][l] = DW'((l + 1) * (k + 1));
         end
      start_job(4);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL identity_in_ready_after_start got=%b want=1", in_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL identity_busy got=%b want=1", busy); end
      feed(4, 1'b0);
      collect();
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL identity_timeout got=%b want=0", tmo); end
      for (int r = 0; r < N; r++) begin
         for (int j = 0; j < N; j++) exp_row[j*ACCW +: ACCW] = ACCW'((r + 1) * (j + 1));
         checks++; if (got_row[r] !== exp_row) begin errors++; $display("FAIL identity_row r=%0d got=%h want=%h", r, got_row[r], exp_row); end
         checks++; if (got_idx[r] !== 2'(r)) begin errors++; $display("FAIL identity_idx r=%0d got=%0d want=%0d", r, got_idx[r], r); end
         checks++; if (got_last[r] !== (r == N - 1)) begin errors++; $display("FAIL identity_last r=%0d got=%b want=%b", r, got_last[r], (r == N - 1)); end
      end
      checks++; if (first_valid_cyc - last_beat_cyc !== 2 * N) begin errors++; $display("FAIL identity_valid_latency got=%0d want=%0d", first_valid_cyc - last_beat_cyc, 2 * N); end
      checks++; if (done_cyc - last_beat_cyc !== 3 * N) begin errors++; $display("FAIL identity_done_latency got=%0d want=%0d", done_cyc - last_beat_cyc, 3 * N); end
      checks++; if (done_at !== 1'b1) begin errors++; $display("FAIL identity_done got=%b want=1", done_at); end
      checks++; if (done_next !== 1'b0) begin errors++; $display("FAIL identity_done_pulse got=%b want=0", done_next); end
      $display("test_identity done");
   endtask

   task automatic test_signed();
      logic [N*ACCW-1:0] exp_row;
      tmo = 1'b0;
      for (int k = 0; k < MAXK; k++)
         for (int l = 0; l < N; l++) begin
            vd[k][l] = 8'h80;
            vw[k][l] = 8'h7F;
         end
      for (int j = 0; j < N; j++) exp_row[j*ACCW +: ACCW] = 24'hC08000;
      start_job(MAXK);
      feed(MAXK, 1'b0);
      collect();
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL signed_timeout got=%b want=0", tmo); end
      for (int r = 0; r < N; r++) begin
         checks++; if (got_row[r] !== exp_row) begin errors++; $display("FAIL signed_row r=%0d got=%h want=%h", r, got_row[r], exp_row); end
      end
      checks++; if (done_at !== 1'b1) begin errors++; $display("FAIL signed_done got=%b want=1", done_at); end
      $display("test_signed done");
   endtask

   task automatic test_stall_backpressure();
      int t;
      int acc_m;
      logic [N*ACCW-1:0] exp_row [N];
      tmo = 1'b0;
      for (int k = 0; k < 5; k++)
         for (int l = 0; l < N; l++) begin
            vd[k][l] = DW'(k * 37 + l * 11 - 60);
            vw[k][l] = DW'(k * 23 - l * 19 + 5);
         end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            acc_m = 0;
            for (int k = 0; k < 5; k++) acc_m += $signed(vd[k][i]) * $signed(vw[k][j]);
            exp_row[i][j*ACCW +: ACCW] = ACCW'(acc_m);
         end
      out_ready = 1'b0;
      start_job(5);
      k_len = KW'(2);
      start = 1'b1;
      tick();
      start = 1'b0;
      feed(5, 1'b1);
      for (int r = 0; r < N; r++) begin
         t = 0;
         while (!out_valid && t < TMO) begin
            tick();
            t++;
         end
         checks++; if (t >= TMO) begin errors++; $display("FAIL stall_wait_valid r=%0d got=timeout want=out_valid", r); end
         for (int s = 0; s < 5; s++) begin
            checks++;
            if (out_valid !== 1'b1 || out_row !== exp_row[r] || out_row_idx !== 2'(r)) begin
               errors++;
               $display("FAIL stall_hold r=%0d s=%0d got valid=%b idx=%0d row=%h want valid=1 idx=%0d row=%h", r, s, out_valid, out_row_idx, out_row, r, exp_row[r]);
            end
            tick();
         end
         out_ready = 1'b1;
         checks++; if (out_row !== exp_row[r]) begin errors++; $display("FAIL stall_row r=%0d got=%h want=%h", r, out_row, exp_row[r]); end
         tick();
         out_ready = 1'b0;
      end
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL stall_feed_timeout got=%b want=0", tmo); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done got=%b want=1", done); end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL stall_done_pulse got=%b want=0", done); end
      $display("test_stall_backpressure done");
   endtask

   task automatic test_klen0();
      int ready_snap;
      tmo = 1'b0;
      ready_snap = ready_cnt;
      start_job(0);
      collect();
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL klen0_timeout got=%b want=0", tmo); end
      for (int r = 0; r < N; r++) begin
         checks++; if (got_row[r] !== '0) begin errors++; $display("FAIL klen0_row r=%0d got=%h want=0", r, got_row[r]); end
      end
      checks++; if (ready_cnt !== ready_snap) begin errors++; $display("FAIL klen0_in_ready cycles got=%0d want=0", ready_cnt - ready_snap); end
      checks++; if (done_at !== 1'b1) begin errors++; $display("FAIL klen0_done got=%b want=1", done_at); end
      $display("test_klen0 done");
   endtask

   task automatic test_back_to_back();
      logic [N*ACCW-1:0] exp_row;
      tmo = 1'b0;
      for (int k = 0; k < 2; k++)
         for (int l = 0; l < N; l++) begin
            vd[k][l] = DW'(3);
            vw[k][l] = DW'(5);
         end
      start_job(2);
      feed(2, 1'b0);
      collect();
      for (int j = 0; j < N; j++) exp_row[j*ACCW +: ACCW] = ACCW'(30);
      checks++; if (got_row[1] !== exp_row) begin errors++; $display("FAIL b2b_first_row got=%h want=%h", got_row[1], exp_row); end
      for (int l = 0; l < N; l++) begin
         vd[0][l] = DW'(l + 1);
         vw[0][l] = DW'(1);
      end
      start_job(1);
      feed(1, 1'b0);
      collect();
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL b2b_timeout got=%b want=0", tmo); end
      for (int r = 0; r < N; r++) begin
         for (int j = 0; j < N; j++) exp_row[j*ACCW +: ACCW] = ACCW'(r + 1);
         checks++; if (got_row[r] !== exp_row) begin errors++; $display("FAIL b2b_second_row r=%0d got=%h want=%h", r, got_row[r], exp_row); end
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_mid_load();
      int done_snap;
      int exp_tab [N][N];
      logic [N*ACCW-1:0] exp_row;
      exp_tab = '{'{8, 10, -4, 2}, '{-4, -5, 2, -1}, '{12, 15, -6, 3}, '{0, 0, 0, 0}};
      tmo = 1'b0;
      for (int k = 0; k < 4; k++)
         for (int l = 0; l < N; l++) begin
            vd[k][l] = DW'(9);
            vw[k][l] = DW'(9);
         end
      start_job(4);
      feed(2, 1'b0);
      done_snap = done_cnt;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready got=%b want=0", in_ready); end
      repeat (12) tick();
      checks++; if (done_cnt !== done_snap) begin errors++; $display("FAIL rst_mid_no_done pulses got=%0d want=0", done_cnt - done_snap); end
      vd[0][0] = 8'd2;  vd[0][1] = 8'hFF; vd[0][2] = 8'd3;  vd[0][3] = 8'd0;
      vw[0][0] = 8'd4;  vw[0][1] = 8'd5;  vw[0][2] = 8'hFE; vw[0][3] = 8'd1;
      start_job(1);
      feed(1, 1'b0);
      collect();
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rst_mid_timeout got=%b want=0", tmo); end
      for (int r = 0; r < N; r++) begin
         for (int j = 0; j < N; j++) exp_row[j*ACCW +: ACCW] = ACCW'(exp_tab[r][j]);
         checks++; if (got_row[r] !== exp_row) begin errors++; $display("FAIL rst_mid_row r=%0d got=%h want=%h", r, got_row[r], exp_row); end
      end
      checks++; if (done_at !== 1'b1) begin errors++; $display("FAIL rst_mid_done got=%b want=1", done_at); end
      $display("test_reset_mid_load done");
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      k_len = '0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_d = '0;
      in_w = '0;
      tmo = 1'b0;
      test_reset();
      test_identity();
      test_signed();
      test_stall_backpressure();
      test_klen0();
      test_back_to_back();
      test_reset_mid_load();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=no_finish want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
